mc_ctrl: RTL

MC_CTRL -- requirements
Module: mc_ctrl

---
 rtl/mc_ctrl.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/mc_ctrl.sv
// rtl/mc_ctrl.sv - multicycle MIPS-subset control FSM with retired-instruction counter
module mc_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  op,
  input  logic [5:0]  funct,
  input  logic        zero,
  output logic        PCWr,
  output logic        IRWr,
  output logic        EXTOp,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ALUOp,
  output logic [1:0]  NPCOp,
  output logic        RegWr,
  output logic        MemWr,
  output logic [1:0]  RegDst,
  output logic [1:0]  MemToReg,
  output logic [3:0]  state,
  output logic        ill,
  output logic [31:0] retired
);

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MADDR  = 4'd2;
  localparam logic [3:0] S_MRD    = 4'd3;
  localparam logic [3:0] S_MWB    = 4'd4;
  localparam logic [3:0] S_MWR    = 4'd5;
  localparam logic [3:0] S_EXR    = 4'd6;
  localparam logic [3:0] S_ALUWB  = 4'd7;
  localparam logic [3:0] S_EXI    = 4'd8;
  localparam logic [3:0] S_BRANCH = 4'd9;
  localparam logic [3:0] S_JUMP   = 4'd10;

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_ORI = 6'b001101;
  localparam logic [5:0] OP_LUI = 6'b001111;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_JAL = 6'b000011;
  localparam logic [5:0] F_ADDU = 6'b100001;
  localparam logic [5:0] F_SUBU = 6'b100011;
  localparam logic [5:0] F_JR   = 6'b001000;

  logic [3:0] nxt;
  logic [5:0] op_q, funct_q, dop, dfn;
  logic is_r, is_addu, is_subu, is_jr, is_ori, is_lui, is_lw, is_sw, is_beq, is_j, is_jal;
  logic ext, term;

  // DECODE looks at the live IR fields; every later state uses the copy taken in DECODE
  assign dop     = (state == S_DECODE) ? op    : op_q;
  assign dfn     = (state == S_DECODE) ? funct : funct_q;
  assign is_r    = (dop == OP_R);
  assign is_addu = is_r && (dfn == F_ADDU);
  assign is_subu = is_r && (dfn == F_SUBU);
  assign is_jr   = is_r && (dfn == F_JR);
  assign is_ori  = (dop == OP_ORI);
  assign is_lui  = (dop == OP_LUI);
  assign is_lw   = (dop == OP_LW);
  assign is_sw   = (dop == OP_SW);
  assign is_beq  = (dop == OP_BEQ);
  assign is_j    = (dop == OP_J);
  assign is_jal  = (dop == OP_JAL);
  assign ext     = is_lw || is_sw || is_beq;
  assign term    = (state == S_MWB) || (state == S_MWR) || (state == S_ALUWB) ||
                   (state == S_BRANCH) || (state == S_JUMP);

  always_comb begin
    nxt      = S_FETCH;
    PCWr     = 1'b0;
    IRWr     = 1'b0;
    EXTOp    = 1'b0;
    ALUSrcB  = 2'd0;
    ALUOp    = 2'd0;
    NPCOp    = 2'd0;
    RegWr    = 1'b0;
    MemWr    = 1'b0;
    RegDst   = 2'd0;
    MemToReg = 2'd0;
    ill      = 1'b0;
    if (state >= S_DECODE && state <= S_JUMP) EXTOp = ext;
    case (state)
      S_FETCH: begin
        IRWr    = 1'b1;
        PCWr    = 1'b1;
        ALUSrcB = 2'd1;
        nxt     = S_DECODE;
      end
      S_DECODE: begin
        if (is_lw || is_sw)                nxt = S_MADDR;
        else if (is_addu || is_subu)       nxt = S_EXR;
        else if (is_ori || is_lui)         nxt = S_EXI;
        else if (is_beq)                   nxt = S_BRANCH;
        else if (is_j || is_jal || is_jr)  nxt = S_JUMP;
        else                               ill = 1'b1;
      end
      S_MADDR: begin
        ALUSrcB = 2'd2;
        nxt     = is_lw ? S_MRD : S_MWR;
      end
      S_MRD: nxt = S_MWB;
      S_MWB: begin
        RegWr    = 1'b1;
        MemToReg = 2'd1;
      end
      S_MWR: MemWr = 1'b1;
      S_EXR: begin
        ALUOp = is_subu ? 2'd1 : 2'd0;
        nxt   = S_ALUWB;
      end
      S_EXI: begin
        ALUSrcB = 2'd2;
        ALUOp   = is_lui ? 2'd3 : 2'd2;
        nxt     = S_ALUWB;
      end
      S_ALUWB: begin
        RegWr  = 1'b1;
        RegDst = is_r ? 2'd1 : 2'd0;
      end
      S_BRANCH: begin
        ALUOp = 2'd1;
        NPCOp = 2'd1;
        PCWr  = zero;
      end
      S_JUMP: begin
        PCWr  = 1'b1;
        NPCOp = is_jr ? 2'd3 : 2'd2;
        if (is_jal) begin
          RegWr    = 1'b1;
          RegDst   = 2'd2;
          MemToReg = 2'd2;
        end
      end
      default: nxt = S_FETCH;
    endcase
    // Held in reset: no write strobe may escape, including FETCH's own
    if (!reset) begin
      PCWr     = 1'b0;
      IRWr     = 1'b0;
      EXTOp    = 1'b0;
      ALUSrcB  = 2'd0;
      ALUOp    = 2'd0;
      NPCOp    = 2'd0;
      RegWr    = 1'b0;
      MemWr    = 1'b0;
      RegDst   = 2'd0;
      MemToReg = 2'd0;
      ill      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_FETCH;
      op_q    <= 6'd0;
      funct_q <= 6'd0;
      retired <= 32'd0;
    end else begin
      state <= nxt;
      if (state == S_DECODE) begin
        op_q    <= op;
        funct_q <= funct;
      end
      if (term) retired <= retired + 32'd1;
    end
  end

endmodule
